// File: rtl/huff_pkg.sv
// huff_pkg: constants and state encoding shared by the Huffman encoder and
// its output bit packer.
//   HUFF_MAX_LEN : default maximum code length in bits
//   HUFF_LEN_W   : default width of the code-length field (2**LEN_W > MAX_LEN)
//   huff_state_e : packer state encoding (StRun accepts codes, StFlush drains tail)
package huff_pkg;

    localparam int unsigned HUFF_MAX_LEN = 16;
    localparam int unsigned HUFF_LEN_W   = 5;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } huff_state_e;

endpackage

// File: rtl/huff_acc_merge.sv
// huff_acc_merge: combinational shift-and-OR that places a right-justified code
// word directly below the current fill of a left-aligned accumulator.
// Ports:
//   acc    in  : current accumulator, valid bits left-aligned, rest zero
//   fill   in  : number of valid bits in acc
//   code   in  : code bits, right-justified; bit len-1 is the earliest
//   len    in  : code length, already clamped to MAX_LEN
//   merged out : acc with the code appended
// The caller guarantees fill + len <= MAX_LEN + 7 whenever merged is used.
module huff_acc_merge
    import huff_pkg::*;
#(
    parameter int unsigned MAX_LEN = HUFF_MAX_LEN,
    parameter int unsigned LEN_W   = HUFF_LEN_W,
    parameter int unsigned ACC_W   = MAX_LEN + 7,
    parameter int unsigned FILL_W  = $clog2(ACC_W + 1)
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [FILL_W-1:0]  fill,
    input  logic [MAX_LEN-1:0] code,
    input  logic [LEN_W-1:0]   len,
    output logic [ACC_W-1:0]   merged
);

    logic [LEN_W-1:0] pre_shift;
    logic [ACC_W-1:0] code_left;

    always_comb begin
        pre_shift = LEN_W'(MAX_LEN) - len;
        // Left-align the code to the accumulator top; bits above len-1 fall
        // off the top, so no explicit mask of the unused code bits is needed.
        code_left = {code, 7'b0} << pre_shift;
        merged    = acc | (code_left >> fill);
    end

endmodule

// File: rtl/huff_bit_packer.sv
// huff_bit_packer: packs variable-length code words (MSB first) into a byte
// stream; on a last-code marker the tail is zero-padded into a final byte.
// Ports:
//   CLK, RESET                : clock, synchronous active-high reset
//   IN_VALID/IN_READY         : code word handshake
//   IN_CODE, IN_LEN, IN_LAST  : right-justified code, its length, end of stream
//   OUT_VALID/OUT_READY       : byte handshake
//   OUT_DATA, OUT_LAST        : packed byte (bit 7 earliest), final-byte flag
//   DONE                      : one-cycle pulse when the flush completes
//   LEN_ERR                   : sticky, a code with IN_LEN > MAX_LEN was accepted
//   BIT_COUNT                 : payload bits accepted since reset
// Build option: define HUFF_PACK_STATS_EN to implement BIT_COUNT; otherwise it
// reads as 0 and no counter exists.
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int unsigned MAX_LEN = HUFF_MAX_LEN,
    parameter int unsigned LEN_W   = HUFF_LEN_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [MAX_LEN-1:0] IN_CODE,
    input  logic [LEN_W-1:0]   IN_LEN,
    input  logic               IN_LAST,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [7:0]         OUT_DATA,
    output logic               OUT_LAST,
    output logic               DONE,
    output logic               LEN_ERR,
    output logic [31:0]        BIT_COUNT
);

    localparam int unsigned ACC_W  = MAX_LEN + 7;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);

    huff_state_e       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              len_err_q, len_err_d;

    logic              len_over;
    logic [LEN_W-1:0]  len_c;
    logic [ACC_W-1:0]  merged;
    logic              accept;
    logic              emit;

    assign len_over = IN_LEN > LEN_W'(MAX_LEN);
    assign len_c    = len_over ? LEN_W'(MAX_LEN) : IN_LEN;

    huff_acc_merge #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .ACC_W   (ACC_W),
        .FILL_W  (FILL_W)
    ) u_merge (
        .acc    (acc_q),
        .fill   (fill_q),
        .code   (IN_CODE),
        .len    (len_c),
        .merged (merged)
    );

    // Outputs decode only registered state, never IN_VALID or OUT_READY.
    assign IN_READY  = (state_q == StRun) && (fill_q <= FILL_W'(7));
    assign OUT_VALID = (fill_q >= FILL_W'(8)) || ((state_q == StFlush) && (fill_q != '0));
    assign OUT_DATA  = acc_q[ACC_W-1 -: 8];
    assign OUT_LAST  = OUT_VALID && (state_q == StFlush) && (fill_q <= FILL_W'(8));
    assign DONE      = (state_q == StFlush) && (fill_q == '0);
    assign LEN_ERR   = len_err_q;

    assign accept = IN_VALID && IN_READY;
    assign emit   = OUT_VALID && OUT_READY;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        len_err_d = len_err_q;
        if (accept) begin
            acc_d  = merged;
            fill_d = fill_q + FILL_W'(len_c);
            if (len_over) begin
                len_err_d = 1'b1;
            end
            if (IN_LAST) begin
                state_d = StFlush;
            end
        end else if (emit) begin
            acc_d  = acc_q << 8;
            fill_d = (fill_q >= FILL_W'(8)) ? fill_q - FILL_W'(8) : '0;
        end else if (DONE) begin
            state_d = StRun;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StRun;
            acc_q     <= '0;
            fill_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            len_err_q <= len_err_d;
        end
    end

`ifdef HUFF_PACK_STATS_EN
    logic [31:0] bit_count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_count_q <= '0;
        end else if (accept) begin
            bit_count_q <= bit_count_q + 32'(len_c);
        end
    end

    assign BIT_COUNT = bit_count_q;
`else
    assign BIT_COUNT = '0;
`endif

endmodule
